// File: rtl/pipe_adder.sv
`default_nettype none
// ============================================================================
// pipe_adder : pipelined WIDTH-bit adder/subtractor, one CHUNK per stage,
//              valid/ready handshake. Optional Ovf output: PIPE_ADDER_OVF_EN.
// Revision   : 1.0
// ============================================================================
module pipe_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             Sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             Cout
`ifdef PIPE_ADDER_OVF_EN
    ,
    output logic             Ovf
`endif
);

    localparam int STAGES = WIDTH / CHUNK;

    logic             adv;

    // Stage k inputs (from ports for k=0, from stage k-1 registers otherwise)
    logic [WIDTH-1:0] a_in   [STAGES];
    logic [WIDTH-1:0] b_in   [STAGES];
    logic [WIDTH-1:0] sum_in [STAGES];
    logic             c_in   [STAGES];
    logic             v_in   [STAGES];

    logic [WIDTH-1:0] a_q    [STAGES];
    logic [WIDTH-1:0] b_q    [STAGES];
    logic [WIDTH-1:0] sum_q  [STAGES];
    logic             c_q    [STAGES];
    logic             v_q    [STAGES];

    logic [CHUNK:0]   part   [STAGES];
    logic [WIDTH-1:0] sum_nx [STAGES];

    assign adv       = !out_valid || out_ready;
    assign in_ready  = adv;
    assign out_valid = v_q[STAGES-1];
    assign S         = sum_q[STAGES-1];
    assign Cout      = c_q[STAGES-1];

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_head
            assign a_in[k]   = A;
            assign b_in[k]   = Sub ? ~B : B;
            assign c_in[k]   = Sub ? ~Cin : Cin;
            assign v_in[k]   = in_valid;
            assign sum_in[k] = '0;
        end else begin : g_body
            assign a_in[k]   = a_q[k-1];
            assign b_in[k]   = b_q[k-1];
            assign c_in[k]   = c_q[k-1];
            assign v_in[k]   = v_q[k-1];
            assign sum_in[k] = sum_q[k-1];
        end

        always_comb begin
            part[k] = (CHUNK+1)'(a_in[k][k*CHUNK +: CHUNK])
                    + (CHUNK+1)'(b_in[k][k*CHUNK +: CHUNK])
                    + (CHUNK+1)'(c_in[k]);
        end

        always_comb begin
            sum_nx[k]                   = sum_in[k];
            sum_nx[k][k*CHUNK +: CHUNK] = part[k][CHUNK-1:0];
        end

        // Data registers only load on a valid slot so bubbles leave S untouched
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                v_q[k]   <= 1'b0;
                sum_q[k] <= '0;
                c_q[k]   <= 1'b0;
            end else if (adv) begin
                v_q[k] <= v_in[k];
                if (v_in[k]) begin
                    sum_q[k] <= sum_nx[k];
                    c_q[k]   <= part[k][CHUNK];
                end
            end
        end

        if (k < STAGES - 1) begin : g_fwd
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    a_q[k] <= '0;
                    b_q[k] <= '0;
                end else if (adv && v_in[k]) begin
                    a_q[k] <= a_in[k];
                    b_q[k] <= b_in[k];
                end
            end
        end
    end

`ifdef PIPE_ADDER_OVF_EN
    logic ovf_q;

    // Carry into MSB is a^b^s at the MSB; XOR with carry out gives overflow
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (adv && v_in[STAGES-1]) begin
            ovf_q <= a_in[STAGES-1][WIDTH-1] ^ b_in[STAGES-1][WIDTH-1]
                   ^ part[STAGES-1][CHUNK-1] ^ part[STAGES-1][CHUNK];
        end
    end

    assign Ovf = ovf_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_adder.sv
`default_nettype none
// ============================================================================
// tb_pipe_adder : directed self-checking bench for pipe_adder (16-bit, 4/stage)
// Revision      : 1.0
// ============================================================================
module tb_pipe_adder;

    localparam int WIDTH  = 16;
    localparam int CHUNK  = 4;
    localparam int STAGES = WIDTH / CHUNK;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Cin;
    logic             Sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] S;
    logic             Cout;
    logic             Ovf;

    int checks = 0;
    int errors = 0;

    pipe_adder #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .Cin       (Cin),
        .Sub       (Sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .S         (S),
        .Cout      (Cout)
`ifdef PIPE_ADDER_OVF_EN
        ,
        .Ovf       (Ovf)
`endif
    );

`ifndef PIPE_ADDER_OVF_EN
    assign Ovf = 1'b0;
`endif

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        sub;
        logic [15:0] s;
        logic        cout;
        logic        ovf;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Single operation: pulse in_valid, measure latency, check the result
    task automatic run_one(input vec_t v, input string tag);
        int lat;
        @(negedge clk);
        in_valid = 1'b1;
        A = v.a;
        B = v.b;
        Cin = v.cin;
        Sub = v.sub;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 12) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, " out_valid"}, 32'(out_valid), 32'd1);
        chk({tag, " latency"}, 32'(lat), 32'(STAGES));
        chk({tag, " S"}, 32'(S), 32'(v.s));
        chk({tag, " Cout"}, 32'(Cout), 32'(v.cout));
`ifdef PIPE_ADDER_OVF_EN
        chk({tag, " Ovf"}, 32'(Ovf), 32'(v.ovf));
`endif
        @(posedge clk);
        #1;
    endtask

    // 8 back-to-back ops A=i, B=0x1000*i; optional out_ready stall window
    task automatic run_stream(input int stall_start, input int stall_len, input string tag);
        int sent;
        int got;
        int cyc;
        int last_cyc;
        logic prev_stall;
        logic [15:0] held_s;
        logic held_c;
        sent = 0;
        got = 0;
        cyc = 0;
        last_cyc = 0;
        prev_stall = 1'b0;
        held_s = '0;
        held_c = 1'b0;
        while (got < 8 && cyc < 60) begin
            @(negedge clk);
            out_ready = !(stall_len > 0 && cyc >= stall_start && cyc < stall_start + stall_len);
            if (sent < 8) begin
                in_valid = 1'b1;
                A = 16'(sent);
                B = 16'(sent * 16'h1000);
                Cin = 1'b0;
                Sub = 1'b0;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (out_valid && out_ready) begin
                chk({tag, " S"}, 32'(S), 32'(got * 16'h1001));
                chk({tag, " Cout"}, 32'(Cout), 32'd0);
                if (got == 0)
                    chk({tag, " first latency"}, 32'(cyc), 32'(STAGES));
                else if (stall_len == 0)
                    chk({tag, " spacing"}, 32'(cyc - last_cyc), 32'd1);
                last_cyc = cyc;
                got++;
            end
            if (out_valid && !out_ready) begin
                chk({tag, " in_ready stall"}, 32'(in_ready), 32'd0);
                if (prev_stall) begin
                    chk({tag, " S held"}, 32'(S), 32'(held_s));
                    chk({tag, " Cout held"}, 32'(Cout), 32'(held_c));
                end
                held_s = S;
                held_c = Cout;
            end
            prev_stall = out_valid && !out_ready;
            if (in_valid && in_ready)
                sent++;
            cyc++;
        end
        chk({tag, " result count"}, 32'(got), 32'd8);
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        #1;
        chk({tag, " drained"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        vecs[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[1] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vecs[2] = '{16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0001, 1'b1, 1'b0};
        vecs[3] = '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0};
        vecs[4] = '{16'h0FFF, 16'h0001, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0};
        vecs[5] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[6] = '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
        vecs[7] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};
        vecs[8] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[9] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};

        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        A = '0;
        B = '0;
        Cin = 1'b0;
        Sub = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset S", 32'(S), 32'd0);
        chk("reset Cout", 32'(Cout), 32'd0);
        chk("reset in_ready", 32'(in_ready), 32'd1);
`ifdef PIPE_ADDER_OVF_EN
        chk("reset Ovf", 32'(Ovf), 32'd0);
`endif

        for (int i = 0; i < 10; i++)
            run_one(vecs[i], $sformatf("vec%0d", i));

        run_stream(0, 0, "stream");
        run_stream(6, 5, "stall");

        // Three ops in flight, reset before any reaches the output
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            A = 16'(16'h0100 * (i + 1));
            B = 16'h0011;
            Cin = 1'b0;
            Sub = 1'b0;
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            #1;
            chk("flush out_valid", 32'(out_valid), 32'd0);
            chk("flush S", 32'(S), 32'd0);
        end
        run_one(vecs[3], "post-reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
